seg_display_driver: RTL and testbench

// - Display-side sink for the CPU's ledData/halt outputs (ecall-driven LED channel).
// - Latches each new ledData word and time-multiplexes it onto a DIGITS-digit

---
 rtl/seg_display_driver_if.sv | 12 +
 rtl/seg_display_driver.sv | 207 ++++++++++++++++++++
 tb/tb_seg_display_driver.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/seg_display_driver_if.sv
// CPU-to-display channel: LED data word, load strobe, halt flag and conversion-busy status.
interface seg_display_driver_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] ledData;
    logic             ledValid;
    logic             halt;
    logic             busy;

    modport master (output ledData, output ledValid, output halt, input busy);
    modport slave  (input ledData, input ledValid, input halt, output busy);
endinterface

// File: rtl/seg_display_driver.sv
// Latches CPU ledData words and scans them onto a common-anode seven-segment display.
// Hex display by default; define DISP_BCD_EN for sequential double-dabble decimal display.
module seg_display_driver #(
    parameter int WIDTH    = 32,
    parameter int DIGITS   = 8,
    parameter int SCAN_DIV = 100000
) (
    input  logic                clk,
    input  logic                rst,
    seg_display_driver_if.slave cpu,
    output logic [DIGITS-1:0]   an,
    output logic [7:0]          seg
);
    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
`ifdef DISP_BCD_EN
    // Enough BCD digits for 2**WIDTH-1, padded so every display digit has a nibble.
    localparam int BCD_W = 4 * ((WIDTH * 30103) / 100000 + 1);
    localparam int VAL_W = (4 * DIGITS > BCD_W) ? 4 * DIGITS : BCD_W;
    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_t;
`else
    localparam int VAL_W = 4 * DIGITS;
`endif

    logic [DIV_W-1:0]  div_q, div_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [VAL_W-1:0]  value_q, value_d;
    logic [DIGITS-1:0] an_q, an_d;
    logic [7:0]        seg_q, seg_d;
    logic [3:0]        nib_s;
    logic              ovf_s;

    function automatic logic [7:0] hex_code(input logic [3:0] n);
        case (n)
            4'h0:    hex_code = 8'hC0;
            4'h1:    hex_code = 8'hF9;
            4'h2:    hex_code = 8'hA4;
            4'h3:    hex_code = 8'hB0;
            4'h4:    hex_code = 8'h99;
            4'h5:    hex_code = 8'h92;
            4'h6:    hex_code = 8'h82;
            4'h7:    hex_code = 8'hF8;
            4'h8:    hex_code = 8'h80;
            4'h9:    hex_code = 8'h90;
            4'hA:    hex_code = 8'h88;
            4'hB:    hex_code = 8'h83;
            4'hC:    hex_code = 8'hC6;
            4'hD:    hex_code = 8'hA1;
            4'hE:    hex_code = 8'h86;
            4'hF:    hex_code = 8'h8E;
            default: hex_code = 8'hFF;
        endcase
    endfunction

`ifdef DISP_BCD_EN
    state_t             state_q, state_d;
    logic [WIDTH-1:0]   sh_q, sh_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic [BCD_W-1:0]   adj_s;
    logic [BCD_W+WIDTH-1:0] cat_s;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               pend_q, pend_d;
    logic [WIDTH-1:0]   pend_data_q, pend_data_d;
    logic               busy_q, busy_d;

    function automatic logic [BCD_W-1:0] dabble_adj(input logic [BCD_W-1:0] b);
        logic [BCD_W-1:0] r;
        r = b;
        for (int i = 0; i < BCD_W / 4; i++) begin
            r[4*i +: 4] = (r[4*i +: 4] >= 4'd5) ? (r[4*i +: 4] + 4'd3) : r[4*i +: 4];
        end
        return r;
    endfunction

    // Any nonzero BCD digit beyond the visible ones means the number does not fit.
    assign ovf_s    = |(value_q >> (4 * DIGITS));
    assign cpu.busy = busy_q;

    // Conversion FSM next state: one double-dabble step per SHIFT cycle, 1-deep pending queue.
    always_comb begin
        state_d     = state_q;
        sh_d        = sh_q;
        bcd_d       = bcd_q;
        cnt_d       = cnt_q;
        pend_d      = pend_q;
        pend_data_d = pend_data_q;
        busy_d      = busy_q;
        value_d     = value_q;
        adj_s       = dabble_adj(bcd_q);
        cat_s       = {adj_s, sh_q} << 1;
        case (state_q)
            ST_IDLE: begin
                if (cpu.ledValid) begin
                    sh_d    = cpu.ledData;
                    bcd_d   = {BCD_W{1'b0}};
                    cnt_d   = {CNT_W{1'b0}};
                    busy_d  = 1'b1;
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                {bcd_d, sh_d} = cat_s;
                cnt_d         = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_SHIFT;
                end
                if (cpu.ledValid) begin
                    pend_d      = 1'b1;
                    pend_data_d = cpu.ledData;
                end else begin
                    pend_d = pend_q;
                end
            end
            ST_DONE: begin
                value_d = VAL_W'(bcd_q);
                // A word arriving in DONE is newer than any pending one, so it wins.
                if (cpu.ledValid || pend_q) begin
                    sh_d    = cpu.ledValid ? cpu.ledData : pend_data_q;
                    bcd_d   = {BCD_W{1'b0}};
                    cnt_d   = {CNT_W{1'b0}};
                    pend_d  = 1'b0;
                    busy_d  = 1'b1;
                    state_d = ST_SHIFT;
                end else begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end
`else
    assign ovf_s    = 1'b0;
    assign cpu.busy = 1'b0;

    // Hex build: the word is displayed directly, last strobe wins.
    always_comb begin
        if (cpu.ledValid) begin
            value_d = VAL_W'(cpu.ledData);
        end else begin
            value_d = value_q;
        end
    end
`endif

    // Scan divider, digit index and next pin pattern for the currently selected digit.
    always_comb begin
        if (div_q == DIV_W'(SCAN_DIV - 1)) begin
            div_d = {DIV_W{1'b0}};
            idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? {IDX_W{1'b0}} : (idx_q + IDX_W'(1));
        end else begin
            div_d = div_q + DIV_W'(1);
            idx_d = idx_q;
        end
        nib_s    = value_q[4*idx_q +: 4];
        an_d     = ~(DIGITS'(1) << idx_q);
        seg_d    = ovf_s ? 8'hBF : hex_code(nib_s);
        seg_d[7] = ~(cpu.halt && (idx_q == {IDX_W{1'b0}}));
    end

    // All state registers, cleared by the asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q       <= {DIV_W{1'b0}};
            idx_q       <= {IDX_W{1'b0}};
            value_q     <= {VAL_W{1'b0}};
            an_q        <= {DIGITS{1'b1}};
            seg_q       <= 8'hFF;
`ifdef DISP_BCD_EN
            state_q     <= ST_IDLE;
            sh_q        <= {WIDTH{1'b0}};
            bcd_q       <= {BCD_W{1'b0}};
            cnt_q       <= {CNT_W{1'b0}};
            pend_q      <= 1'b0;
            pend_data_q <= {WIDTH{1'b0}};
            busy_q      <= 1'b0;
`endif
        end else begin
            div_q       <= div_d;
            idx_q       <= idx_d;
            value_q     <= value_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
`ifdef DISP_BCD_EN
            state_q     <= state_d;
            sh_q        <= sh_d;
            bcd_q       <= bcd_d;
            cnt_q       <= cnt_d;
            pend_q      <= pend_d;
            pend_data_q <= pend_data_d;
            busy_q      <= busy_d;
`endif
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
endmodule

// File: tb/tb_seg_display_driver.sv
// Directed self-checking bench for seg_display_driver (SCAN_DIV=4, DIGITS=8, WIDTH=32);
// exercises the decimal build too when DISP_BCD_EN is defined.
module tb_seg_display_driver;
    logic       clk;
    logic       rst;
    logic [7:0] an;
    logic [7:0] seg;
    int         errors;
    int         checks;
    int         ecnt;

    seg_display_driver_if #(.WIDTH(32)) bus ();

    seg_display_driver #(.WIDTH(32), .DIGITS(8), .SCAN_DIV(4)) dut (
        .clk (clk),
        .rst (rst),
        .cpu (bus),
        .an  (an),
        .seg (seg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Rising edges since reset release; selects which digit should be lit.
    always @(posedge clk or negedge rst) begin
        if (!rst) ecnt <= 0;
        else      ecnt <= ecnt + 1;
    end

    function automatic logic [7:0] exp_code(input logic [3:0] n);
        case (n)
            4'h0: exp_code = 8'hC0;  4'h1: exp_code = 8'hF9;
            4'h2: exp_code = 8'hA4;  4'h3: exp_code = 8'hB0;
            4'h4: exp_code = 8'h99;  4'h5: exp_code = 8'h92;
            4'h6: exp_code = 8'h82;  4'h7: exp_code = 8'hF8;
            4'h8: exp_code = 8'h80;  4'h9: exp_code = 8'h90;
            4'hA: exp_code = 8'h88;  4'hB: exp_code = 8'h83;
            4'hC: exp_code = 8'hC6;  4'hD: exp_code = 8'hA1;
            4'hE: exp_code = 8'h86;  default: exp_code = 8'h8E;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Checks n consecutive cycles of the scan against the expected digit pattern.
    task automatic check_scan(input logic [31:0] disp, input logic dash, input logic h,
                              input logic eb, input int n);
        int         k;
        logic [7:0] ea;
        logic [7:0] es;
        for (int i = 0; i < n; i++) begin
            k  = ((ecnt - 1) / 4) % 8;
            ea = ~(8'd1 << k);
            es = dash ? 8'hBF : exp_code(disp[4*k +: 4]);
            if (h && k == 0) es[7] = 1'b0;
            chk("an", {24'd0, an}, {24'd0, ea});
            chk("seg", {24'd0, seg}, {24'd0, es});
            chk("busy", {31'd0, bus.busy}, {31'd0, eb});
            tick(1);
        end
    endtask

    task automatic strobe(input logic [31:0] d);
        bus.ledValid = 1'b1;
        bus.ledData  = d;
        tick(1);
        bus.ledValid = 1'b0;
    endtask

    initial begin
        errors       = 0;
        checks       = 0;
        rst          = 1'b0;
        bus.ledValid = 1'b0;
        bus.ledData  = 32'd0;
        bus.halt     = 1'b0;
        tick(3);
        chk("rst_an", {24'd0, an}, 32'h0000_00FF);
        chk("rst_seg", {24'd0, seg}, 32'h0000_00FF);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        rst = 1'b1;
        tick(1);
        chk("first_an", {24'd0, an}, 32'h0000_00FE);
        chk("first_seg", {24'd0, seg}, 32'h0000_00C0);
        check_scan(32'h0, 1'b0, 1'b0, 1'b0, 8);

`ifdef DISP_BCD_EN
        strobe(32'h00BC614E);
        check_scan(32'h0, 1'b0, 1'b0, 1'b1, 33);
        chk("bcd1_busy_drop", {31'd0, bus.busy}, 32'd0);
        tick(1);
        check_scan(32'h12345678, 1'b0, 1'b0, 1'b0, 32);

        strobe(32'd100000000);
        check_scan(32'h12345678, 1'b0, 1'b0, 1'b1, 33);
        chk("ovf_busy_drop", {31'd0, bus.busy}, 32'd0);
        tick(1);
        check_scan(32'h0, 1'b1, 1'b0, 1'b0, 32);

        bus.ledData  = 32'd5;
        bus.ledValid = 1'b1;
        tick(1);
        bus.ledValid = 1'b0;
        for (int i = 0; i < 66; i++) begin
            chk("chain_busy", {31'd0, bus.busy}, 32'd1);
            if (i == 3) begin
                bus.ledData  = 32'd9;
                bus.ledValid = 1'b1;
            end else begin
                bus.ledValid = 1'b0;
            end
            tick(1);
        end
        bus.ledValid = 1'b0;
        chk("chain_busy_drop", {31'd0, bus.busy}, 32'd0);
        tick(1);
        check_scan(32'h9, 1'b0, 1'b0, 1'b0, 16);

        strobe(32'd5);
        tick(3);
`else
        strobe(32'h12345678);
        tick(1);
        check_scan(32'h12345678, 1'b0, 1'b0, 1'b0, 33);

        bus.halt = 1'b1;
        strobe(32'h0);
        tick(1);
        check_scan(32'h0, 1'b0, 1'b1, 1'b0, 32);
        bus.halt = 1'b0;

        bus.ledValid = 1'b1;
        bus.ledData  = 32'hDEADBEEF;
        tick(1);
        bus.ledData  = 32'h0000ABCD;
        tick(1);
        bus.ledValid = 1'b0;
        tick(1);
        check_scan(32'h0000ABCD, 1'b0, 1'b0, 1'b0, 32);
`endif

        rst = 1'b0;
        #1;
        chk("midrst_an", {24'd0, an}, 32'h0000_00FF);
        chk("midrst_seg", {24'd0, seg}, 32'h0000_00FF);
        chk("midrst_busy", {31'd0, bus.busy}, 32'd0);
        tick(1);
        rst = 1'b1;
        tick(1);
        chk("rerun_an", {24'd0, an}, 32'h0000_00FE);
        chk("rerun_seg", {24'd0, seg}, 32'h0000_00C0);
        chk("rerun_busy", {31'd0, bus.busy}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
